// File: rtl/tc2sm_converter_32_pkg.sv
// ============================================================================
// Module   : tc2sm_converter_32_pkg
// Brief    : Shared state encodings and default widths for tc2sm_converter_32.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tc2sm_converter_32_pkg;

  localparam int c_DATA_W  = 32;
  localparam int c_CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tc2sm_converter_32_inc_chunk.sv
// ============================================================================
// Module   : half_adder / inc_chunk
// Brief    : Half-adder cell and the CHUNK_W-bit ~chunk + cin chain built from it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module inc_chunk #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] chunk_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               cout_o
);
  logic [CHUNK_W:0] w_carry;

  assign w_carry[0] = cin_i;

  genvar i;
  generate
    for (i = 0; i < CHUNK_W; i++) begin : g_ha
      half_adder u_ha (
        .a_i    (~chunk_i[i]),
        .b_i    (w_carry[i]),
        .sum_o  (sum_o[i]),
        .carry_o(w_carry[i+1])
      );
    end
  endgenerate

  assign cout_o = w_carry[CHUNK_W];
endmodule

`default_nettype wire

// File: rtl/tc2sm_converter_32.sv
// ============================================================================
// Module   : tc2sm_converter_32
// Brief    : Chunk-serial two's-complement to sign-magnitude converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tc2sm_converter_32
  import tc2sm_converter_32_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int CHUNK_W = c_CHUNK_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              sign_o,
  output logic [DATA_W-1:0] mag_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int c_NCHUNK = DATA_W / CHUNK_W;
  localparam int c_CNT_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                sign_r_q, sign_r_d;
  logic                carry_q, carry_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic                sign_out_q, sign_out_d;
  logic [DATA_W-1:0]   mag_out_q, mag_out_d;

  logic [CHUNK_W-1:0]  w_inc_sum;
  logic                w_inc_cout;
  logic [CHUNK_W-1:0]  w_chunk;

  inc_chunk #(.CHUNK_W(CHUNK_W)) u_inc (
    .chunk_i(shift_q[CHUNK_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (w_inc_sum),
    .cout_o (w_inc_cout)
  );

  assign w_chunk = sign_r_q ? w_inc_sum : shift_q[CHUNK_W-1:0];

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    sign_r_d   = sign_r_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    sign_out_d = sign_out_q;
    mag_out_d  = mag_out_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          shift_d  = data_i;
          sign_r_d = data_i[DATA_W-1];
          carry_d  = 1'b1;
          cnt_d    = '0;
          drain_d  = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // The cycle after the last chunk copies the result into the output stage.
        if (drain_q) begin
          drain_d    = 1'b0;
          sign_out_d = sign_r_q;
          mag_out_d  = acc_q;
          state_d    = DONE;
        end else begin
          acc_d   = {w_chunk, acc_q[DATA_W-1:CHUNK_W]};
          shift_d = shift_q >> CHUNK_W;
          if (sign_r_q) begin
            carry_d = w_inc_cout;
          end
          if (cnt_q == c_CNT_W'(c_NCHUNK - 1)) begin
            cnt_d   = '0;
            drain_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      sign_r_q   <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      sign_out_q <= 1'b0;
      mag_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      sign_r_q   <= sign_r_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      sign_out_q <= sign_out_d;
      mag_out_q  <= mag_out_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign sign_o  = sign_out_q;
  assign mag_o   = mag_out_q;

endmodule

`default_nettype wire

// File: tb/tb_tc2sm_converter_32.sv
// ============================================================================
// Module   : tb_tc2sm_converter_32
// Brief    : Directed and random self-checking bench for tc2sm_converter_32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tc2sm_converter_32;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        sign_o;
  logic [31:0] mag_o;
  logic        valid_o;
  logic        ready_i = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  tc2sm_converter_32 dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .sign_o   (sign_o),
    .mag_o    (mag_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic accept_word(input logic [31:0] x);
    int w;
    w = 0;
    while (!ready_o && w < 20) begin
      step();
      w++;
    end
    n_chk++;
    if (!ready_o) $display("FAIL accept_wait: ready_o=%0b required 1", ready_o);
    else n_pass++;
    data_i  = x;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    step();
    while (!valid_o && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    step();
    step();
    n_chk++;
    if ({ready_o, valid_o, sign_o, mag_o} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_state: ready=%0b valid=%0b sign=%0b mag=%h required 1 0 0 00000000",
               ready_o, valid_o, sign_o, mag_o);
    else n_pass++;
    sys_rst_n = 1'b1;
    step();
  endtask

  task automatic test_vectors();
    logic [31:0] vin  [5];
    logic        vsg  [5];
    logic [31:0] vmag [5];
    int lat;
    vin[0] = 32'hFFFF_FFFF; vsg[0] = 1'b1; vmag[0] = 32'h0000_0001;
    vin[1] = 32'h8000_0000; vsg[1] = 1'b1; vmag[1] = 32'h8000_0000;
    vin[2] = 32'h7FFF_FFFF; vsg[2] = 1'b0; vmag[2] = 32'h7FFF_FFFF;
    vin[3] = 32'hFFFF_FF00; vsg[3] = 1'b1; vmag[3] = 32'h0000_0100;
    vin[4] = 32'h0000_0000; vsg[4] = 1'b0; vmag[4] = 32'h0000_0000;
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      accept_word(vin[i]);
      wait_valid(lat);
      n_chk++;
      if (lat !== 5) $display("FAIL latency[%0d]: got %0d cycles required 5", i, lat);
      else n_pass++;
      n_chk++;
      if ({sign_o, mag_o} !== {vsg[i], vmag[i]})
        $display("FAIL vector[%0d] in=%h: sign=%0b mag=%h required sign=%0b mag=%h",
                 i, vin[i], sign_o, mag_o, vsg[i], vmag[i]);
      else n_pass++;
      step();
      n_chk++;
      if ({ready_o, valid_o} !== 2'b10)
        $display("FAIL ready_return[%0d]: ready=%0b valid=%0b required 1 0", i, ready_o, valid_o);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bad;
    ready_i = 1'b0;
    accept_word(32'hFFFF_FFFE);
    wait_valid(lat);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid_i = i[0];
      data_i  = 32'h0000_0055;
      step();
      if ({valid_o, ready_o, sign_o, mag_o} !== {1'b1, 1'b0, 1'b1, 32'h2}) begin
        if (!bad)
          $display("FAIL bp_hold cycle %0d: valid=%0b ready=%0b sign=%0b mag=%h required 1 0 1 00000002",
                   i, valid_o, ready_o, sign_o, mag_o);
        bad = 1'b1;
      end
    end
    n_chk++;
    if (!bad) n_pass++;
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    n_chk++;
    if ({ready_o, valid_o, sign_o, mag_o} !== {1'b1, 1'b0, 1'b1, 32'h2})
      $display("FAIL bp_release: ready=%0b valid=%0b sign=%0b mag=%h required 1 0 1 00000002",
               ready_o, valid_o, sign_o, mag_o);
    else n_pass++;
    step();
    step();
    n_chk++;
    if (ready_o !== 1'b1) $display("FAIL bp_no_accept: ready=%0b required 1", ready_o);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat;
    ready_i = 1'b1;
    accept_word(32'h1234_5678);
    step();
    sys_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ready_o, valid_o, sign_o, mag_o} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL abort_state: ready=%0b valid=%0b sign=%0b mag=%h required 1 0 0 00000000",
               ready_o, valid_o, sign_o, mag_o);
    else n_pass++;
    step();
    sys_rst_n = 1'b1;
    step();
    accept_word(32'hEDCB_A988);
    wait_valid(lat);
    n_chk++;
    if ({lat == 5, sign_o, mag_o} !== {1'b1, 1'b1, 32'h1234_5678})
      $display("FAIL after_abort: lat=%0d sign=%0b mag=%h required 5 1 12345678", lat, sign_o, mag_o);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [32:0] expq[$];
    logic [32:0] e;
    logic [31:0] specials [4];
    logic [31:0] x;
    bit acc;
    int words, cyc, errs;
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h7FFF_FFFF;
    words = 0; cyc = 0; errs = 0;
    data_i  = $urandom;
    valid_i = 1'b1;
    ready_i = ($urandom_range(0, 3) != 0);
    while (words < 2000 && cyc < 40000) begin
      acc = valid_i && ready_o;
      if (acc) begin
        x = data_i;
        expq.push_back({x[31], x[31] ? 32'(-x) : x});
      end
      if (valid_o && ready_i) begin
        n_chk++;
        if (expq.size() == 0) begin
          $display("FAIL rnd_unexpected: sign=%0b mag=%h with no word outstanding", sign_o, mag_o);
        end else begin
          e = expq.pop_front();
          if ({sign_o, mag_o} !== e) begin
            if (errs < 10)
              $display("FAIL rnd_word %0d: sign=%0b mag=%h required sign=%0b mag=%h",
                       words, sign_o, mag_o, e[32], e[31:0]);
            errs++;
          end else n_pass++;
        end
        words++;
      end
      step();
      cyc++;
      if (acc) data_i = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      ready_i = ($urandom_range(0, 3) != 0);
    end
    valid_i = 1'b0;
    n_chk++;
    if (words !== 2000) $display("FAIL rnd_timeout: completed %0d words required 2000", words);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
